// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer.
// A radix-2 shift-add multiplier and a restoring divider work on operand
// magnitudes for XLEN cycles. The sign fix-up and output select are applied in FIN.
// Divide-by-zero and signed overflow skip the iteration loop entirely.
//
// Handshake: start is sampled only while IDLE, together with op/a/b. busy is
// high from the edge that accepts start until the edge that raises valid.
// valid is a one-cycle strobe, and result holds until the next valid. flush
// returns to IDLE on the next edge without a valid, and flush wins over start.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result,
    output logic [1:0]      dbg_state
);

    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic              special_q, special_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Start-time decode: signedness, magnitudes and special-case detection.
    logic            sgn_a_in, sgn_b_in, div_zero, div_ovf;
    logic [XLEN-1:0] abs_a, abs_b;
    always_comb begin
        sgn_a_in = (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM) && a[XLEN-1];
        sgn_b_in = (op == OP_MULH || op == OP_DIV || op == OP_REM) && b[XLEN-1];
        abs_a    = sgn_a_in ? -a : a;
        abs_b    = sgn_b_in ? -b : b;
        div_zero = op[2] && (b == '0);
        div_ovf  = (op == OP_DIV || op == OP_REM) && (a == MIN_NEG) && (b == '1);
    end

    // One iteration step: shift-add for multiply, shift-subtract for divide.
    // The accumulator holds {high partial, remaining multiplier bits} or {remainder, dividend/quotient bits}.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN:0]   div_sh;
    logic [XLEN:0]     div_try;
    logic [2*XLEN-1:0] div_next;
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                            : {1'b0, acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1:1]};
        div_sh   = {acc_q, 1'b0};
        div_try  = div_sh[2*XLEN:XLEN] - {1'b0, opnd_q};
        div_next = div_try[XLEN] ? div_sh[2*XLEN-1:0]
                                 : {div_try[XLEN-1:0], div_sh[XLEN-1:1], 1'b1};
    end

    // Sign fix-up and output select applied in FIN.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fin_result;
    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (special_q) begin
            fin_result = acc_q[XLEN-1:0];
        end else if (op_q == OP_MUL) begin
            fin_result = prod_fix[XLEN-1:0];
        end else if (!op_q[2]) begin
            fin_result = prod_fix[2*XLEN-1:XLEN];
        end else if (!op_q[1]) begin
            fin_result = quo_fix;
        end else begin
            fin_result = rem_fix;
        end
    end

    // Next-state logic for the IDLE/CALC/FIN sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        special_d = special_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        valid_d   = 1'b0;
        result_d  = result_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_d      = op;
                        neg_a_d   = sgn_a_in;
                        neg_b_d   = sgn_b_in;
                        cnt_d     = '0;
                        special_d = div_zero || div_ovf;
                        opnd_d    = op[2] ? abs_b : abs_a;
                        if (div_zero) begin
                            acc_d   = {{XLEN{1'b0}}, (op[1] ? a : {XLEN{1'b1}})};
                            state_d = S_FIN;
                        end else if (div_ovf) begin
                            acc_d   = {{XLEN{1'b0}}, (op[1] ? {XLEN{1'b0}} : MIN_NEG)};
                            state_d = S_FIN;
                        end else begin
                            acc_d   = {{XLEN{1'b0}}, (op[2] ? abs_a : abs_b)};
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_FIN: begin
                    valid_d  = 1'b1;
                    result_d = fin_result;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers; asynchronous reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            special_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            valid_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            special_q <= special_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign valid     = valid_q;
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative sequencer for the RV32M multiply/divide operations that the single-cycle ALU path does not cover (MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU, plus MUL). It sits beside the ALU in the execute stage and accepts one operation at a time from the decode/control logic. It runs a radix-2 shift-add multiplier or a restoring divider over XLEN iterations and holds the pipeline via `busy` until it returns a one-cycle `valid` result.

## Interface
- XLEN, 32, operand/result width; iteration count equals XLEN
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  XLEN  rs1 operand, sampled with start
- b  in  XLEN  rs2 operand, sampled with start
- flush  in  1  abort current operation (pipeline redirect)
- busy  out  1  high from the cycle after start acceptance until the valid cycle (exclusive); drives the stall
- valid  out  1  one-cycle result strobe
- result  out  XLEN  registered result; holds last value until the next valid

## Operation
- States: IDLE, CALC, FIN.
- IDLE: on start, latch op, operand signs, and absolute values, then clear the iteration counter.
  - Signedness is decided by op: MULH takes both operands signed; MULHSU takes a signed and b unsigned; DIV/REM take both signed; the rest are unsigned.
  - The state goes to CALC, or goes directly to FIN for the special cases below.
- CALC: one iteration per cycle, counter 0..XLEN-1; go to FIN after iteration XLEN-1.
  - Multiply: a 2·XLEN product accumulator does shift-add on |b| bits, LSB first.
  - Divide: a restoring shift-subtract produces the quotient and remainder on magnitudes.
- FIN: apply the sign fix, select the output, register `result`, pulse `valid`, and return to IDLE.
  - Product sign is sign(a) xor sign(b) for signed ops. Output is the low XLEN bits for MUL and the high XLEN bits for MULH*.
  - Quotient sign is sign(a) xor sign(b). Remainder sign is sign(a).
- Special cases, detected at start, skip CALC:
  - Divide by zero: quotient = all ones; remainder = a.
  - Signed overflow (a = 0x80000000, b = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000; remainder = 0.
- Start while not IDLE is ignored; operands are not re-sampled.
- Flush in any state forces IDLE on the next edge. No valid is produced and `result` is unchanged. Flush has priority over start in the same cycle.
- Simultaneous FIN and start: start is ignored (not IDLE); the requester re-issues.

## Timing
- Reset values: state IDLE, busy 0, valid 0, result 0, counter 0, and all internal registers 0.
- Reset asserted mid-operation aborts immediately (asynchronous) and produces no valid.
- Normal op, start sampled at edge E:
  - busy is high after E.
  - Iterations occur on edges E+1..E+XLEN.
  - FIN executes at edge E+XLEN+1. valid and result appear after it, and busy falls at the same edge.
  - Latency is XLEN+1 cycles (33 for XLEN = 32).
- Special case: FIN is entered at E and valid appears after E+1 (2-cycle latency).
- A new start is accepted in the cycle valid is high (state is IDLE then); back-to-back issue is allowed.
- Counter width is $clog2(XLEN). The iteration end is decided on counter == XLEN-1, with no wrap past it.

## Test plan
- MUL a = 7, b = 0xFFFFFFFD (-3):
  - result 0xFFFFFFEB.
  - valid exactly 33 cycles after the start cycle.
  - busy high for 33 cycles.
- MULH 0x80000000 × 0x80000000 gives 0x40000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFF.
- Division, including a/b sign combinations:
  - DIV -7/2 gives 0xFFFFFFFD.
  - REM -7/2 gives 0xFFFFFFFF.
  - DIVU 100/7 gives 14.
  - REMU 100/7 gives 2.
- Special cases, each with valid 2 cycles after start:
  - DIVU 5/0 gives 0xFFFFFFFF.
  - REM 5/0 gives 5.
  - DIV 0x80000000/-1 gives 0x80000000.
  - REM of the same operands gives 0.
- Flush asserted at iteration 10:
  - state returns to IDLE next cycle with busy 0.
  - no valid; result keeps its old value.
  - a new start then completes normally.
- Control corner cases:
  - rst_n pulsed low mid-CALC clears all outputs asynchronously.
  - start pulsed while busy is ignored: exactly one valid, with the original operands' result.
  - start in the valid cycle is accepted back-to-back.
